// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package disp_pkg;

    // Per-slot phase: all digits dark, then one digit lit.
    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // True when a nibble is a legal BCD digit.
    function automatic logic is_bcd(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; the default arm covers A..F.
    always_comb begin
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS common-cathode digits through one shared decoder, with
// anti-ghosting blanking per slot and a frame-synchronous double buffer.
module display_scan_controller
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    lz_suppress,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    pending,
    output logic                    frame_done,
    output logic                    bcd_err
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // With no blanking configured the FSM never visits S_BLANK, not even out of reset.
    localparam scan_state_e SLOT_START = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

    scan_state_e        state_q,      state_d;
    logic [IDX_W-1:0]   idx_q,        idx_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [VAL_W-1:0]   display_q,    display_d;
    logic [VAL_W-1:0]   shadow_q,     shadow_d;
    logic               pending_q,    pending_d;
    logic [6:0]         seg_q,        seg_d;
    logic [NUM_DIGITS-1:0] en_q,      en_d;
    logic               frame_done_q, frame_done_d;
    logic               bcd_err_q,    bcd_err_d;

    logic               slot_end;
    logic               boundary;
    logic [3:0]         cur_nibble;
    logic               upper_zero;
    logic               lz_blank;
    logic [6:0]         dec_seg;
    logic               take_update;

    // True when every nibble of v is a legal BCD digit.
    function automatic logic all_bcd(input logic [VAL_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(v[4*i +: 4])) ok = 1'b0;
        end
        return ok;
    endfunction

    assign slot_end = (cnt_q == SLOT_LAST);
    assign boundary = slot_end && (idx_q == IDX_LAST);

    // Slot counter, digit index and blank/show state sequencing.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (slot_end) begin
            cnt_d   = '0;
            state_d = SLOT_START;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else if (state_q == S_BLANK && cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
        end
    end

    // Select the current digit's nibble and decide whether it is a suppressed leading zero.
    always_comb begin
        cur_nibble = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_nibble = display_q[4*i +: 4];
            if (IDX_W'(i) >= idx_q && display_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        lz_blank = lz_suppress && (idx_q != '0) && upper_zero;
    end

    bcd_to_7seg u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Next values of the registered pin drivers.
    always_comb begin
        seg_d        = SEG_OFF;
        en_d         = '0;
        frame_done_d = boundary;
        if (state_q == S_SHOW && !lz_blank) begin
            seg_d = dec_seg;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                en_d[i] = (idx_q == IDX_W'(i));
            end
        end
    end

    // Double buffer: loads land in the shadow, the display copies it only at a frame boundary.
    always_comb begin
        shadow_d    = shadow_q;
        display_d   = display_q;
        pending_d   = pending_q;
        bcd_err_d   = bcd_err_q;
        take_update = 1'b0;
        if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                display_d   = value_in;
                pending_d   = 1'b0;
                take_update = 1'b1;
            end else if (pending_q) begin
                display_d   = shadow_q;
                pending_d   = 1'b0;
                take_update = 1'b1;
            end
        end
        if (take_update) bcd_err_d = !all_bcd(display_d);
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (rst) begin
            state_q      <= SLOT_START;
            idx_q        <= '0;
            cnt_q        <= '0;
            // NOTE: display/shadow are ordinary registers, reset so the panel starts on a defined 0.
            display_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            en_q         <= '0;
            frame_done_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            display_q    <= display_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign seg_out    = seg_q;
    assign digit_en   = en_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign bcd_err    = bcd_err_q;

endmodule
